// File: rtl/ring_fifo.sv
// Single-clock circular FIFO with registered read data, occupancy-decoded status
// flags and sticky overflow/underflow error flags.
module ring_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     writeEnable,
    input  logic [WIDTH-1:0]         data,
    output logic                     writeAck,
    input  logic                     readEnable,
    output logic                     dataReadAck,
    output logic [WIDTH-1:0]         dataRead,
    input  logic                     flush,
    input  logic                     clearErrors,
    output logic [$clog2(DEPTH):0]   bufferLength,
    output logic                     full,
    output logic                     empty,
    output logic                     almostFull,
    output logic                     almostEmpty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             rd_ok;
    logic             wr_ok;
    logic             rd_err;
    logic             wr_err;

    // A full FIFO still accepts a write when a read frees the head slot at the same edge.
    always_comb begin
        rd_ok  = readEnable && !flush && (bufferLength != '0);
        wr_ok  = writeEnable && !flush && ((bufferLength != FULL_CNT) || rd_ok);
        rd_err = readEnable && !flush && !rd_ok;
        wr_err = writeEnable && !flush && !wr_ok;
    end

    always_comb begin
        full        = (bufferLength == FULL_CNT);
        empty       = (bufferLength == '0);
        almostFull  = (bufferLength >= AFULL_CNT);
        almostEmpty = (bufferLength <= AEMPTY_CNT);
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            bufferLength <= '0;
            writeAck     <= 1'b0;
            dataReadAck  <= 1'b0;
            dataRead     <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wptr         <= '0;
            rptr         <= '0;
            bufferLength <= '0;
            writeAck     <= 1'b0;
            dataReadAck  <= 1'b0;
        end else begin
            writeAck    <= wr_ok;
            dataReadAck <= rd_ok;
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr     <= rptr + 1'b1;
                dataRead <= mem[rptr];
            end
            if (wr_ok && !rd_ok) begin
                bufferLength <= bufferLength + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                bufferLength <= bufferLength - 1'b1;
            end
            overflow  <= wr_err || (overflow && !clearErrors);
            underflow <= rd_err || (underflow && !clearErrors);
        end
    end

endmodule

// File: tb/tb_ring_fifo.sv
// Self-checking bench for ring_fifo (WIDTH=8, DEPTH=4): directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_ring_fifo;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         writeEnable = 1'b0;
    logic [W-1:0] data = '0;
    logic         writeAck;
    logic         readEnable = 1'b0;
    logic         dataReadAck;
    logic [W-1:0] dataRead;
    logic         flush = 1'b0;
    logic         clearErrors = 1'b0;
    logic [2:0]   bufferLength;
    logic         full, empty, almostFull, almostEmpty, overflow, underflow;

    int ntot = 0;
    int nbad = 0;

    // reference model state
    logic [W-1:0] q[$];
    logic         m_wack, m_rack, m_ov, m_un;
    logic [W-1:0] m_rdata;

    ring_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .writeEnable(writeEnable), .data(data),
        .writeAck(writeAck), .readEnable(readEnable), .dataReadAck(dataReadAck),
        .dataRead(dataRead), .flush(flush), .clearErrors(clearErrors),
        .bufferLength(bufferLength), .full(full), .empty(empty),
        .almostFull(almostFull), .almostEmpty(almostEmpty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of requests, advance the model across the edge, sample 1 ns later.
    task automatic step(input bit we, input logic [W-1:0] d, input bit re,
                        input bit fl = 1'b0, input bit ce = 1'b0, input bit rs = 1'b0);
        bit rok, wok;
        writeEnable = we; data = d; readEnable = re;
        flush = fl; clearErrors = ce; reset = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_wack = 0; m_rack = 0; m_rdata = '0; m_ov = 0; m_un = 0;
        end else if (fl) begin
            q.delete();
            m_wack = 0; m_rack = 0;
        end else begin
            rok = re && (q.size() > 0);
            wok = we && ((q.size() < D) || rok);
            if (ce) begin m_ov = 0; m_un = 0; end
            if (we && !wok) m_ov = 1;
            if (re && !rok) m_un = 1;
            m_rack = rok;
            m_wack = wok;
            if (rok) m_rdata = q.pop_front();
            if (wok) q.push_back(d);
        end
        #1;
        writeEnable = 0; readEnable = 0; flush = 0; clearErrors = 0; reset = 0;
    endtask

    task automatic test_reset;
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1);
        ntot++; if (bufferLength !== 3'd0) begin nbad++; $display("FAIL reset_len got=%0d want=0", bufferLength); end
        ntot++; if (writeAck !== 1'b0) begin nbad++; $display("FAIL reset_wack got=%b want=0", writeAck); end
        ntot++; if (dataReadAck !== 1'b0) begin nbad++; $display("FAIL reset_rack got=%b want=0", dataReadAck); end
        ntot++; if (dataRead !== 8'h00) begin nbad++; $display("FAIL reset_rdata got=%h want=00", dataRead); end
        ntot++; if ({overflow, underflow} !== 2'b00) begin nbad++; $display("FAIL reset_err got=%b want=00", {overflow, underflow}); end
        ntot++; if ({empty, almostEmpty, full, almostFull} !== 4'b1100) begin nbad++; $display("FAIL reset_flags got=%b want=1100", {empty, almostEmpty, full, almostFull}); end
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(i), 1'b0);
            ntot++; if (writeAck !== 1'b1) begin nbad++; $display("FAIL fill_wack%0d got=%b want=1", i, writeAck); end
            ntot++; if (bufferLength !== 3'(i)) begin nbad++; $display("FAIL fill_len%0d got=%0d want=%0d", i, bufferLength, i); end
            ntot++; if (almostFull !== (i >= 3)) begin nbad++; $display("FAIL fill_afull%0d got=%b want=%b", i, almostFull, i >= 3); end
            ntot++; if (full !== (i == 4)) begin nbad++; $display("FAIL fill_full%0d got=%b want=%b", i, full, i == 4); end
        end
        step(1'b1, 8'h05, 1'b0);
        ntot++; if (writeAck !== 1'b0) begin nbad++; $display("FAIL ovf_wack got=%b want=0", writeAck); end
        ntot++; if (overflow !== 1'b1) begin nbad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        ntot++; if (bufferLength !== 3'd4) begin nbad++; $display("FAIL ovf_len got=%0d want=4", bufferLength); end
    endtask

    task automatic test_drain_underflow;
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, '0, 1'b1);
            ntot++; if (dataReadAck !== 1'b1) begin nbad++; $display("FAIL drain_rack%0d got=%b want=1", i, dataReadAck); end
            ntot++; if (dataRead !== 8'(i)) begin nbad++; $display("FAIL drain_data%0d got=%h want=%h", i, dataRead, 8'(i)); end
        end
        ntot++; if (empty !== 1'b1) begin nbad++; $display("FAIL drain_empty got=%b want=1", empty); end
        step(1'b0, '0, 1'b1);
        ntot++; if (dataReadAck !== 1'b0) begin nbad++; $display("FAIL udf_rack got=%b want=0", dataReadAck); end
        ntot++; if (dataRead !== 8'h04) begin nbad++; $display("FAIL udf_hold got=%h want=04", dataRead); end
        ntot++; if (underflow !== 1'b1) begin nbad++; $display("FAIL udf_flag got=%b want=1", underflow); end
    endtask

    task automatic test_wrap;
        logic [W-1:0] want[4] = '{8'h12, 8'h13, 8'h14, 8'h15};
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h13 + i), 1'b0);
        ntot++; if (bufferLength !== 3'd4) begin nbad++; $display("FAIL wrap_len got=%0d want=4", bufferLength); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            ntot++; if (dataRead !== want[i] || dataReadAck !== 1'b1) begin nbad++; $display("FAIL wrap_data%0d got=%h/%b want=%h/1", i, dataRead, dataReadAck, want[i]); end
        end
    endtask

    task automatic test_full_rw;
        logic [W-1:0] want[4] = '{8'h21, 8'h22, 8'h23, 8'hAA};
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        ntot++; if ({overflow, underflow} !== 2'b00) begin nbad++; $display("FAIL clr_err got=%b want=00", {overflow, underflow}); end
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        ntot++; if ({writeAck, dataReadAck} !== 2'b11) begin nbad++; $display("FAIL frw_acks got=%b want=11", {writeAck, dataReadAck}); end
        ntot++; if (dataRead !== 8'h20) begin nbad++; $display("FAIL frw_data got=%h want=20", dataRead); end
        ntot++; if (bufferLength !== 3'd4 || overflow !== 1'b0) begin nbad++; $display("FAIL frw_len_ovf got=%0d/%b want=4/0", bufferLength, overflow); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            ntot++; if (dataRead !== want[i]) begin nbad++; $display("FAIL frw_drain%0d got=%h want=%h", i, dataRead, want[i]); end
        end
    endtask

    task automatic test_empty_rw;
        step(1'b1, 8'h55, 1'b1);
        ntot++; if ({writeAck, dataReadAck} !== 2'b10) begin nbad++; $display("FAIL erw_acks got=%b want=10", {writeAck, dataReadAck}); end
        ntot++; if (underflow !== 1'b1 || bufferLength !== 3'd1) begin nbad++; $display("FAIL erw_udf_len got=%b/%0d want=1/1", underflow, bufferLength); end
        step(1'b0, '0, 1'b1);
        ntot++; if (dataRead !== 8'h55 || dataReadAck !== 1'b1) begin nbad++; $display("FAIL erw_read got=%h/%b want=55/1", dataRead, dataReadAck); end
    endtask

    task automatic test_flush_clear_reset;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        ntot++; if (bufferLength !== 3'd3) begin nbad++; $display("FAIL fl_pre_len got=%0d want=3", bufferLength); end
        step(1'b1, 8'h3F, 1'b1, 1'b1);
        ntot++; if (bufferLength !== 3'd0 || empty !== 1'b1) begin nbad++; $display("FAIL fl_len got=%0d/%b want=0/1", bufferLength, empty); end
        ntot++; if ({writeAck, dataReadAck} !== 2'b00) begin nbad++; $display("FAIL fl_acks got=%b want=00", {writeAck, dataReadAck}); end
        ntot++; if ({overflow, underflow} !== 2'b01) begin nbad++; $display("FAIL fl_err got=%b want=01", {overflow, underflow}); end
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b1, 8'h4F, 1'b0, 1'b0, 1'b1);
        ntot++; if ({overflow, underflow} !== 2'b10) begin nbad++; $display("FAIL clr_race got=%b want=10", {overflow, underflow}); end
        step(1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 1'b1);
        ntot++; if ({bufferLength, writeAck, dataReadAck, dataRead, overflow, underflow} !== 15'd0) begin nbad++; $display("FAIL midrst got=%0d %b %b %h %b %b want=all zero", bufferLength, writeAck, dataReadAck, dataRead, overflow, underflow); end
        ntot++; if ({empty, almostEmpty, full, almostFull} !== 4'b1100) begin nbad++; $display("FAIL midrst_flags got=%b want=1100", {empty, almostEmpty, full, almostFull}); end
        step(1'b1, 8'h61, 1'b0);
        ntot++; if (writeAck !== 1'b1 || bufferLength !== 3'd1) begin nbad++; $display("FAIL post_rst got=%b/%0d want=1/1", writeAck, bufferLength); end
    endtask

    task automatic test_random;
        int n;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 8),
                 1'($urandom_range(0, 99) < 2));
            n = q.size();
            ntot++;
            if (writeAck !== m_wack || dataReadAck !== m_rack || dataRead !== m_rdata ||
                bufferLength !== 3'(n) || overflow !== m_ov || underflow !== m_un ||
                full !== (n == D) || empty !== (n == 0) || almostFull !== (n >= D - 1) ||
                almostEmpty !== (n <= 1)) begin
                nbad++;
                $display("FAIL rand%0d got=%b%b %h len%0d ov%b un%b f%b e%b af%b ae%b want=%b%b %h len%0d ov%b un%b",
                         i, writeAck, dataReadAck, dataRead, bufferLength, overflow, underflow,
                         full, empty, almostFull, almostEmpty, m_wack, m_rack, m_rdata, n, m_ov, m_un);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        test_flush_clear_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule

// File: doc/ring_fifo.md
RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 4, entry count; SHALL be a power of two, at least 2.
REQ-003 Parameter AFULL_LEVEL, default DEPTH-1, count at or above which almostFull asserts.
REQ-004 Parameter AEMPTY_LEVEL, default 1, count at or below which almostEmpty asserts.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 writeEnable  input  1  write request this cycle.
REQ-009 data  input  WIDTH  write data.
REQ-010 writeAck  output  1  registered; previous-edge write accepted.
REQ-011 readEnable  input  1  read request this cycle.
REQ-012 dataReadAck  output  1  registered; dataRead valid, previous-edge read accepted.
REQ-013 dataRead  output  WIDTH  registered read data.
REQ-014 flush  input  1  discard all contents.
REQ-015 clearErrors  input  1  clear sticky error flags.
REQ-016 bufferLength  output  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH.
REQ-017 full, empty, almostFull, almostEmpty  output  1 each  decoded from bufferLength.
REQ-018 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-019 Write accepted at an edge when writeEnable=1, flush=0, and (bufferLength<DEPTH, or bufferLength=DEPTH with a read accepted at the same edge).
REQ-020 Accepted write stores data at write pointer, advances pointer modulo DEPTH, writeAck=1 for the following cycle only.
REQ-021 Read accepted at an edge when readEnable=1, flush=0, bufferLength>0 (value before the edge).
REQ-022 Accepted read: dataRead = head entry, dataReadAck=1 for the following cycle, read pointer advances modulo DEPTH; latency one cycle.
REQ-023 No write-to-read bypass: read on empty is rejected even with a same-cycle write.
REQ-024 Rejected read: dataReadAck=0, dataRead holds last value, underflow set.
REQ-025 Rejected write (full, no concurrent accepted read): writeAck=0, storage and pointers unchanged, overflow set.
REQ-026 bufferLength +1 on write only, -1 on read only, unchanged on both or neither.
REQ-027 full = (bufferLength==DEPTH); empty = (bufferLength==0); almostFull = (bufferLength>=AFULL_LEVEL); almostEmpty = (bufferLength<=AEMPTY_LEVEL).
REQ-028 flush=1: pointers and bufferLength to 0, requests that cycle ignored, acks 0 next cycle, no error flagged, overflow/underflow unchanged.
REQ-029 clearErrors=1 clears overflow and underflow; a new error at the same edge wins (flag stays 1).
REQ-030 Priority: reset > flush > read/write.
REQ-031 Storage contents are not cleared by reset or flush; only pointers and count.

Reset
REQ-032 reset=1 at an edge: pointers 0, bufferLength 0, writeAck 0, dataReadAck 0, dataRead 0, overflow 0, underflow 0; hence empty 1, almostEmpty 1, full 0, almostFull 0.
REQ-033 Reset mid-operation discards all requests that edge; FIFO usable the next cycle.

Verification (WIDTH=8, DEPTH=4, default levels)
REQ-034 Reset, write 0x01..0x04 back-to-back -> writeAck 1 each, bufferLength 1,2,3,4, almostFull at 3, full at 4; write 0x05 -> writeAck 0, overflow 1, bufferLength 4.
REQ-035 Then 4 reads -> dataRead 0x01,0x02,0x03,0x04 with dataReadAck 1, empty 1; 5th read -> dataReadAck 0, dataRead stays 0x04, underflow 1.
REQ-036 Wrap: write 0x10,0x11,0x12, read 2, write 0x13,0x14,0x15 -> bufferLength 4, reads return 0x12,0x13,0x14,0x15.
REQ-037 Full plus simultaneous read and write 0xAA -> both acks 1, bufferLength stays 4, overflow unchanged, 0xAA returned last.
REQ-038 Empty plus simultaneous read and write 0x55 -> writeAck 1, dataReadAck 0, underflow 1, bufferLength 1; next read returns 0x55.
REQ-039 bufferLength 3, flush -> bufferLength 0, empty 1, errors unchanged; clearErrors with concurrent full-write -> overflow stays 1; reset mid-write -> all REQ-032 values next cycle.
